// File: rtl/alu_seq_if.sv
// Execute-stage bus for the sequential ALU: operands and request in, registered result and flags out.
interface alu_seq_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [2:0]       Op;
  logic             sign;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Out;
  logic             Ofl;
  logic             zero;
  logic             div0;

  modport master (
    output start, Op, sign, A, B,
    input  busy, done, Out, Ofl, zero, div0
  );

  modport slave (
    input  start, Op, sign, A, B,
    output busy, done, Out, Ofl, zero, div0
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU: single-cycle ADD/SUB/AND/XOR plus iterative shift-add multiply and
// restoring divide, signed or unsigned, behind a start/busy/done handshake.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  alu_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] LAST = WIDTH[WIDTH-1:0] - 1'b1;

  state_t             state_reg, state_next;
  logic [WIDTH-1:0]   cnt_reg, cnt_next;
  logic [1:0]         kind_reg, kind_next;
  logic               sgn_reg, sgn_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic [WIDTH-1:0]   b_mag_reg, b_mag_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   rem_reg, rem_next;
  logic [WIDTH-1:0]   out_reg, out_next;
  logic               ofl_reg, ofl_next;
  logic               div0_reg, div0_next;
  logic               done_reg, done_next;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [WIDTH-1:0]   sub_diff;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, remr;

  always_comb begin
    a_mag    = (bus.sign && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_mag    = (bus.sign && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    add_sum  = {1'b0, bus.A} + {1'b0, bus.B};
    sub_diff = bus.A - bus.B;
    // Multiply: low half of acc holds the multiplier and is shifted out as the product grows in.
    mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, b_mag_reg} : '0);
    // Divide: low half of acc holds dividend bits in, quotient bits out.
    div_shift = {rem_reg, acc_reg[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, b_mag_reg};
    div_diff  = div_shift[WIDTH-1:0] - b_mag_reg;
    prod      = neg_q_reg ? -acc_reg : acc_reg;
    quo       = neg_q_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    remr      = neg_r_reg ? -rem_reg : rem_reg;
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    kind_next  = kind_reg;
    sgn_next   = sgn_reg;
    neg_q_next = neg_q_reg;
    neg_r_next = neg_r_reg;
    b_mag_next = b_mag_reg;
    acc_next   = acc_reg;
    rem_next   = rem_reg;
    out_next   = out_reg;
    ofl_next   = ofl_reg;
    div0_next  = div0_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (!bus.Op[2]) begin
            done_next = 1'b1;
            div0_next = 1'b0;
            ofl_next  = 1'b0;
            case (bus.Op[1:0])
              2'b00: begin
                out_next = add_sum[WIDTH-1:0];
                ofl_next = bus.sign ? ((bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                                       (add_sum[WIDTH-1] != bus.A[WIDTH-1]))
                                    : add_sum[WIDTH];
              end
              2'b01: begin
                out_next = sub_diff;
                ofl_next = bus.sign ? ((bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                                       (sub_diff[WIDTH-1] != bus.A[WIDTH-1]))
                                    : (bus.A < bus.B);
              end
              2'b10:   out_next = bus.A & bus.B;
              default: out_next = bus.A ^ bus.B;
            endcase
          end else if (bus.Op[1] && (bus.B == '0)) begin
            done_next = 1'b1;
            div0_next = 1'b1;
            ofl_next  = 1'b0;
            out_next  = bus.Op[0] ? bus.A : ONES;
          end else begin
            kind_next  = bus.Op[1:0];
            sgn_next   = bus.sign;
            neg_q_next = bus.sign & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
            neg_r_next = bus.sign & bus.A[WIDTH-1];
            b_mag_next = b_mag;
            acc_next   = {{WIDTH{1'b0}}, a_mag};
            rem_next   = '0;
            cnt_next   = '0;
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (kind_reg[1]) begin
          rem_next = div_ge ? div_diff : div_shift[WIDTH-1:0];
          acc_next = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-2:0], div_ge};
        end else begin
          acc_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) state_next = FIX;
      end
      FIX: begin
        done_next  = 1'b1;
        div0_next  = 1'b0;
        state_next = IDLE;
        case (kind_reg)
          2'b00: begin
            out_next = prod[WIDTH-1:0];
            ofl_next = sgn_reg ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                               : (prod[2*WIDTH-1:WIDTH] != '0);
          end
          2'b01: begin
            out_next = prod[2*WIDTH-1:WIDTH];
            ofl_next = 1'b0;
          end
          2'b10: begin
            out_next = quo;
            // Only most-negative / -1 yields a positive quotient with its MSB set.
            ofl_next = sgn_reg && !neg_q_reg && acc_reg[WIDTH-1];
          end
          default: begin
            out_next = remr;
            ofl_next = 1'b0;
          end
        endcase
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      kind_reg  <= '0;
      sgn_reg   <= 1'b0;
      neg_q_reg <= 1'b0;
      neg_r_reg <= 1'b0;
      b_mag_reg <= '0;
      acc_reg   <= '0;
      rem_reg   <= '0;
      out_reg   <= '0;
      ofl_reg   <= 1'b0;
      div0_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      kind_reg  <= kind_next;
      sgn_reg   <= sgn_next;
      neg_q_reg <= neg_q_next;
      neg_r_reg <= neg_r_next;
      b_mag_reg <= b_mag_next;
      acc_reg   <= acc_next;
      rem_reg   <= rem_next;
      out_reg   <= out_next;
      ofl_reg   <= ofl_next;
      div0_reg  <= div0_next;
      done_reg  <= done_next;
    end
  end

  assign bus.busy = (state_reg != IDLE);
  assign bus.done = done_reg;
  assign bus.Out  = out_reg;
  assign bus.Ofl  = ofl_reg;
  assign bus.div0 = div0_reg;
  assign bus.zero = ~|out_reg;
endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, hand-written multi-cycle corner sequences,
// and random operations checked against an integer-arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic clk;
  logic rst_n;

  alu_seq_if #(.WIDTH(W)) bus();

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] out;
    logic        ofl;
    logic        dz;
  } res_t;

  typedef struct {
    logic [2:0]  op;
    logic        sg;
    logic [15:0] a;
    logic [15:0] b;
    res_t        exp;
  } vec_t;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] prev_out = '0;
  vec_t        vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer arithmetic on the operands' numeric values.
  function automatic res_t model(input logic [2:0] op, input logic sg,
                                 input logic [15:0] a, input logic [15:0] b);
    longint sa, sb, r;
    res_t   res;
    res = '0;
    sa  = sg ? longint'($signed(a)) : longint'(a);
    sb  = sg ? longint'($signed(b)) : longint'(b);
    case (op)
      3'd0: begin
        r = sa + sb;
        res.out = r[15:0];
        res.ofl = sg ? (r > 32767 || r < -32768) : (r > 65535);
      end
      3'd1: begin
        r = sa - sb;
        res.out = r[15:0];
        res.ofl = sg ? (r > 32767 || r < -32768) : (sa < sb);
      end
      3'd2: res.out = a & b;
      3'd3: res.out = a ^ b;
      3'd4: begin
        r = sa * sb;
        res.out = r[15:0];
        res.ofl = sg ? (r > 32767 || r < -32768) : (r > 65535);
      end
      3'd5: begin
        r = sa * sb;
        res.out = r[31:16];
      end
      3'd6: begin
        if (b == 16'h0) begin
          res.out = 16'hFFFF;
          res.dz  = 1'b1;
        end else begin
          r = sa / sb;
          res.out = r[15:0];
          res.ofl = sg && (r > 32767);
        end
      end
      default: begin
        if (b == 16'h0) begin
          res.out = a;
          res.dz  = 1'b1;
        end else begin
          r = sa % sb;
          res.out = r[15:0];
        end
      end
    endcase
    return res;
  endfunction

  task automatic add_vec(input logic [2:0] op, input logic sg, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] out, input logic ofl,
                         input logic dz);
    vec_t v;
    v.op  = op;
    v.sg  = sg;
    v.a   = a;
    v.b   = b;
    v.exp = '{out: out, ofl: ofl, dz: dz};
    vq.push_back(v);
  endtask

  // Issue one op (start sampled on the next edge), then wait for done and check it.
  // inject_at > 0 pulses a bogus start with new operands at that cycle of the run.
  task automatic run_op(input logic [2:0] op, input logic sg, input logic [15:0] a,
                        input logic [15:0] b, input res_t exp, input int inject_at);
    int   lat, busy_cnt, exp_lat, exp_busy;
    logic got, hold_ok;
    exp_lat  = (op[2] && !(op[1] && b == 16'h0)) ? W + 2 : 1;
    exp_busy = (exp_lat == 1) ? 0 : W + 1;
    bus.Op    = op;
    bus.sign  = sg;
    bus.A     = a;
    bus.B     = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    lat = 1; busy_cnt = 0; got = 1'b0; hold_ok = 1'b1;
    while (!got && lat <= 40) begin
      if (bus.done) begin
        got = 1'b1;
      end else begin
        if (bus.busy) busy_cnt++;
        if (bus.Out !== prev_out) hold_ok = 1'b0;
        if (inject_at > 0 && lat == inject_at) begin
          bus.start = 1'b1;
          bus.Op    = 3'd0;
          bus.A     = 16'($urandom);
          bus.B     = 16'($urandom);
        end else if (inject_at > 0 && lat == inject_at + 1) begin
          bus.start = 1'b0;
        end
        @(posedge clk);
        #1;
        lat++;
      end
    end
    bus.start = 1'b0;
    $display("op=%0d sign=%0b A=%h B=%h -> Out=%h Ofl=%b div0=%b zero=%b lat=%0d busy_cycles=%0d",
             op, sg, a, b, bus.Out, bus.Ofl, bus.div0, bus.zero, lat, busy_cnt);
    chk("latency",      32'(lat),      32'(exp_lat));
    chk("busy_cycles",  32'(busy_cnt), 32'(exp_busy));
    chk("busy_at_done", 32'(bus.busy), 32'(0));
    chk("out",          32'(bus.Out),  32'(exp.out));
    chk("ofl",          32'(bus.Ofl),  32'(exp.ofl));
    chk("div0",         32'(bus.div0), 32'(exp.dz));
    chk("zero",         32'(bus.zero), 32'(exp.out == 16'h0));
    if (exp_lat > 1) chk("out_hold", 32'(hold_ok), 32'(1));
    prev_out = exp.out;
  endtask

  logic [2:0]  r_op;
  logic        r_sg;
  logic [15:0] r_a, r_b;
  logic        seen;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.Op    = '0;
    bus.sign  = 1'b0;
    bus.A     = '0;
    bus.B     = '0;

    add_vec(3'd0, 1'b1, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0);
    add_vec(3'd0, 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0);
    add_vec(3'd1, 1'b0, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0);
    add_vec(3'd1, 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b0);
    add_vec(3'd2, 1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0);
    add_vec(3'd3, 1'b0, 16'hF0F0, 16'hFF00, 16'h0FF0, 1'b0, 1'b0);
    add_vec(3'd4, 1'b0, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0);
    add_vec(3'd5, 1'b0, 16'h0100, 16'h0100, 16'h0001, 1'b0, 1'b0);
    add_vec(3'd4, 1'b1, 16'hFFFD, 16'h0005, 16'hFFF1, 1'b0, 1'b0);
    add_vec(3'd5, 1'b1, 16'hFFFD, 16'h0005, 16'hFFFF, 1'b0, 1'b0);
    add_vec(3'd4, 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1, 1'b0);
    add_vec(3'd5, 1'b0, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
    add_vec(3'd6, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 1'b0, 1'b0);
    add_vec(3'd7, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 1'b0, 1'b0);
    add_vec(3'd6, 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 1'b1, 1'b0);
    add_vec(3'd7, 1'b1, 16'h8000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
    add_vec(3'd6, 1'b0, 16'h1234, 16'h0000, 16'hFFFF, 1'b0, 1'b1);
    add_vec(3'd7, 1'b0, 16'h1234, 16'h0000, 16'h1234, 1'b0, 1'b1);
    add_vec(3'd6, 1'b0, 16'h0064, 16'h0007, 16'h000E, 1'b0, 1'b0);
    add_vec(3'd7, 1'b0, 16'h0064, 16'h0007, 16'h0002, 1'b0, 1'b0);

    #12;
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_out",  32'(bus.Out),  32'(0));
    chk("rst_ofl",  32'(bus.Ofl),  32'(0));
    chk("rst_div0", 32'(bus.div0), 32'(0));
    chk("rst_zero", 32'(bus.zero), 32'(1));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back to back (each start lands in the previous done cycle).
    foreach (vq[i]) run_op(vq[i].op, vq[i].sg, vq[i].a, vq[i].b, vq[i].exp, 0);

    @(posedge clk);
    #1;
    chk("done_width", 32'(bus.done), 32'(0));

    // Start pulsed mid-multiply is ignored; next MULH issued in the done cycle.
    run_op(3'd4, 1'b0, 16'h0003, 16'h0005, model(3'd4, 1'b0, 16'h0003, 16'h0005), 5);
    run_op(3'd5, 1'b0, 16'h0100, 16'h0100, model(3'd5, 1'b0, 16'h0100, 16'h0100), 0);

    // Asynchronous reset during RUN cycle 8 aborts the multiply.
    bus.Op = 3'd4; bus.sign = 1'b0; bus.A = 16'h1234; bus.B = 16'h5678;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'(0));
    chk("abort_out",  32'(bus.Out),  32'(0));
    chk("abort_zero", 32'(bus.zero), 32'(1));
    chk("abort_done", 32'(bus.done), 32'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'(0));
    prev_out = '0;
    run_op(3'd6, 1'b0, 16'h0064, 16'h0007, model(3'd6, 1'b0, 16'h0064, 16'h0007), 0);

    // Random operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      r_op = 3'($urandom_range(0, 7));
      r_sg = 1'($urandom_range(0, 1));
      r_a  = 16'($urandom);
      r_b  = 16'($urandom);
      case ($urandom_range(0, 7))
        0: r_b = 16'h0;
        1: begin r_a = 16'h8000; r_b = 16'hFFFF; end
        default: ;
      endcase
      run_op(r_op, r_sg, r_a, r_b, model(r_op, r_sg, r_a, r_b), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
